// File: rtl/rx32_m_pkg.sv
// Shared types and operation decode helpers for the Rx32 M-extension unit.
package rx32_m_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } m_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } md_state_t;

    function automatic logic is_div(input m_op_t op);
        return op[2];
    endfunction

    function automatic logic is_rem(input m_op_t op);
        return op[2] & op[1];
    endfunction

    function automatic logic a_signed(input m_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic b_signed(input m_op_t op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/md_abs_neg.sv
// Conditional two's-complement negate; used both for operand magnitude and result sign fix.
module md_abs_neg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] fixed
);

    assign fixed = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring divide,
// one bit per cycle, with sign handled by magnitude conversion and a final negate.
module mul_div_unit
    import rx32_m_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    md_state_t          state_reg;
    m_op_t              op_reg;
    logic               sign_reg;
    logic [CW-1:0]      count_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0]   opb_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [WIDTH-1:0]   result_reg;

    m_op_t            op_in;
    logic             sign_a, sign_b, start_sign;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             div_zero, div_ovf, special;

    assign op_in  = m_op_t'(op);
    assign sign_a = a_signed(op_in) & a[WIDTH-1];
    assign sign_b = b_signed(op_in) & b[WIDTH-1];
    assign start_sign = is_rem(op_in) ? sign_a : (sign_a ^ sign_b);

    md_abs_neg #(.WIDTH(WIDTH)) u_abs_a (.value(a), .negate(sign_a), .fixed(a_mag));
    md_abs_neg #(.WIDTH(WIDTH)) u_abs_b (.value(b), .negate(sign_b), .fixed(b_mag));

    assign div_zero = is_div(op_in) && (b == '0);
    assign div_ovf  = is_div(op_in) && a_signed(op_in) && (a == MIN_NEG) && (b == '1);
    assign special  = div_zero | div_ovf;

    // Special cases preload the accumulator as {remainder, quotient} so FINISH stays uniform.
    logic [2*WIDTH-1:0] special_acc;
    assign special_acc = div_zero ? {a, {WIDTH{1'b1}}}
                                  : {{WIDTH{1'b0}}, MIN_NEG};

    // Multiply step: acc = {partial product high, remaining multiplier bits}.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                    + {1'b0, (acc_reg[0] ? opb_reg : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

    // Divide step: acc = {remainder, dividend bits shifting into quotient}.
    logic [WIDTH:0]     part_rem;
    logic               q_bit;
    logic [WIDTH-1:0]   trial, new_rem;
    logic [2*WIDTH-1:0] div_next;
    assign part_rem = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    assign q_bit    = part_rem >= {1'b0, opb_reg};
    assign trial    = part_rem[WIDTH-1:0] - opb_reg;
    assign new_rem  = q_bit ? trial : part_rem[WIDTH-1:0];
    assign div_next = {new_rem, acc_reg[WIDTH-2:0], q_bit};

    logic [2*WIDTH-1:0] fix_in, fix_out;
    logic [WIDTH-1:0]   result_next;
    assign fix_in = !is_div(op_reg) ? acc_reg
                  : is_rem(op_reg)  ? {{WIDTH{1'b0}}, acc_reg[2*WIDTH-1:WIDTH]}
                  :                   {{WIDTH{1'b0}}, acc_reg[WIDTH-1:0]};

    md_abs_neg #(.WIDTH(2*WIDTH)) u_fix (.value(fix_in), .negate(sign_reg), .fixed(fix_out));

    assign result_next = (op_reg == OP_MUL || is_div(op_reg)) ? fix_out[WIDTH-1:0]
                                                              : fix_out[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            op_reg     <= OP_MUL;
            sign_reg   <= 1'b0;
            count_reg  <= '0;
            acc_reg    <= '0;
            opb_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            result_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            if (flush) begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start) begin
                            op_reg    <= op_in;
                            busy_reg  <= 1'b1;
                            count_reg <= '0;
                            if (special) begin
                                state_reg <= FINISH;
                                acc_reg   <= special_acc;
                                sign_reg  <= 1'b0;
                            end else begin
                                state_reg <= CALC;
                                sign_reg  <= start_sign;
                                acc_reg   <= {{WIDTH{1'b0}}, (is_div(op_in) ? a_mag : b_mag)};
                                opb_reg   <= is_div(op_in) ? b_mag : a_mag;
                            end
                        end
                    end
                    CALC: begin
                        acc_reg   <= is_div(op_reg) ? div_next : mul_next;
                        count_reg <= count_reg + CW'(1);
                        if (count_reg == CW'(WIDTH - 1))
                            state_reg <= FINISH;
                    end
                    FINISH: begin
                        result_reg <= result_next;
                        done_reg   <= 1'b1;
                        busy_reg   <= 1'b0;
                        state_reg  <= IDLE;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = result_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed RV32M vectors, flush, busy-start and reset cases.
module tb_mul_div_unit;

    localparam int W = 32;
    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;
    localparam int LAT_CALC = W + 1;
    localparam int LAT_SPEC = 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done;
    logic [W-1:0] result;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .op(op),
        .a(a), .b(b), .busy(busy), .done(done), .result(result)
    );

    typedef struct {
        logic [W-1:0] res;
        int           edge_no;
        string        name;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int           edge_cnt = 0;
    logic [W-1:0] last_res = '0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check_val(string name, logic [W-1:0] act, logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic check_int(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT pulses done.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got result %h, required no done", result);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_val({e.name, "_result"}, result, e.res);
                    check_int({e.name, "_done_edge"}, edge_cnt, e.edge_no);
                    $display("txn %-14s result=%h expected=%h edge=%0d", e.name, result, e.res, edge_cnt);
                end
            end
        end
    end

    // Issue one operation, scramble operands after sampling, optionally pulse start mid-flight.
    task automatic run_op(string name, logic [2:0] o, logic [W-1:0] av, logic [W-1:0] bv,
                          logic [W-1:0] exp_res, int lat, int pulse_at);
        int n;
        @(negedge clk);
        op = o; a = av; b = bv; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 3'($urandom); a = $urandom; b = $urandom;
        sb.push_back('{exp_res, edge_cnt + lat, name});
        last_res = exp_res;
        n = 0;
        while (busy && n < 100) begin
            if (n == pulse_at) begin
                @(negedge clk);
                start = 1'b1; op = MUL; a = 32'd3; b = 32'd4;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
        end
        check_int({name, "_busy_cycles"}, n, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_busy", {31'b0, busy}, '0);
        check_val("reset_done", {31'b0, done}, '0);
        check_val("reset_result", result, '0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mul_7_m3",     MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, LAT_CALC, -1);
        run_op("mulh_min_min", MULH,   32'h80000000, 32'h80000000, 32'h40000000, LAT_CALC, -1);
        run_op("mulhu_max",    MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT_CALC, -1);
        run_op("mulhsu_max",   MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT_CALC, -1);
        run_op("mulh_m7_2",    MULH,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LAT_CALC, -1);
        run_op("div_m7_2",     DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LAT_CALC, -1);
        run_op("rem_m7_2",     REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LAT_CALC, -1);
        run_op("divu_100_7",   DIVU,   32'd100,      32'd7,        32'd14,       LAT_CALC, -1);
        run_op("remu_100_7",   REMU,   32'd100,      32'd7,        32'd2,        LAT_CALC, -1);
        run_op("divu_5_0",     DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, LAT_SPEC, -1);
        run_op("remu_5_0",     REMU,   32'd5,        32'd0,        32'd5,        LAT_SPEC, -1);
        run_op("rem_m7_0",     REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, LAT_SPEC, -1);
        run_op("div_ovf",      DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_SPEC, -1);
        run_op("rem_ovf",      REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        LAT_SPEC, -1);
        run_op("divu_busy_st", DIVU,   32'd100,      32'd7,        32'd14,       LAT_CALC, 5);

        // Flush on cycle 10 of a DIV, with a simultaneous start that must be dropped.
        @(negedge clk);
        op = DIV; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1; start = 1'b1; op = MUL; a = 32'd3; b = 32'd4;
        @(posedge clk);
        #1;
        flush = 1'b0; start = 1'b0;
        check_val("flush_busy", {31'b0, busy}, '0);
        check_val("flush_done", {31'b0, done}, '0);
        check_val("flush_result", result, last_res);
        repeat (40) @(posedge clk);
        #1;
        check_val("flush_result_held", result, last_res);

        // Asynchronous reset at cycle 15 of a MUL.
        @(negedge clk);
        op = MUL; a = 32'd7; b = 32'd9; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("arst_busy", {31'b0, busy}, '0);
        check_val("arst_done", {31'b0, done}, '0);
        check_val("arst_result", result, '0);
        last_res = '0;
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mul_3_4",      MUL,    32'd3,        32'd4,        32'd12,       LAT_CALC, -1);

        repeat (5) @(posedge clk);
        #1;
        check_int("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
